// File: rtl/ysyx_rob.sv
// ============================================================================
// Module   : ysyx_rob
// Brief    : Reorder buffer that allocates tags at issue, tracks out-of-order
//            writeback with operand lookup, and retires in program order.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_rob #(
  parameter int ROB_SIZE = 4,
  parameter int XLEN     = 32,
  localparam int TAGW    = $clog2(ROB_SIZE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alloc_valid,
  input  logic [4:0]      alloc_rd,
  input  logic [XLEN-1:0] alloc_pc,
  output logic            alloc_ready,
  output logic [TAGW-1:0] alloc_dest,
  input  logic            wb_valid,
  input  logic [TAGW-1:0] wb_dest,
  input  logic [XLEN-1:0] wb_result,
  input  logic [XLEN-1:0] wb_npc,
  input  logic            wb_pc_change,
  input  logic [TAGW-1:0] lkp_tag_a,
  input  logic [TAGW-1:0] lkp_tag_b,
  output logic            lkp_ready_a,
  output logic            lkp_ready_b,
  output logic [XLEN-1:0] lkp_data_a,
  output logic [XLEN-1:0] lkp_data_b,
  output logic            commit_valid,
  output logic [4:0]      commit_rd,
  output logic [TAGW-1:0] commit_dest,
  output logic [XLEN-1:0] commit_result,
  output logic [XLEN-1:0] commit_pc,
  output logic [XLEN-1:0] commit_npc,
  output logic            flush,
  output logic [TAGW-1:0] count
);

  localparam int IDXW = $clog2(ROB_SIZE);
  localparam logic [TAGW-1:0] c_full = TAGW'(ROB_SIZE);

  logic [ROB_SIZE-1:0] r_busy;
  logic [ROB_SIZE-1:0] r_done;
  logic [ROB_SIZE-1:0] r_pc_change;
  logic [4:0]          r_rd     [ROB_SIZE];
  logic [XLEN-1:0]     r_pc     [ROB_SIZE];
  logic [XLEN-1:0]     r_result [ROB_SIZE];
  logic [XLEN-1:0]     r_npc    [ROB_SIZE];
  logic [IDXW-1:0]     r_head;
  logic [IDXW-1:0]     r_tail;
  logic [TAGW-1:0]     r_count;

  logic [IDXW-1:0] w_wb_idx;
  logic            w_wb_hit;
  logic            w_alloc_fire;

  assign w_wb_idx     = IDXW'(wb_dest - TAGW'(1));
  // Tags above ROB_SIZE alias real entries after truncation, so reject them.
  assign w_wb_hit     = wb_valid && (wb_dest != '0) && (wb_dest <= c_full) && r_busy[w_wb_idx];
  assign alloc_ready  = (r_count != c_full);
  assign alloc_dest   = {1'b0, r_tail} + TAGW'(1);
  assign w_alloc_fire = alloc_valid && alloc_ready && !flush;

  assign commit_valid  = r_busy[r_head] && r_done[r_head];
  assign flush         = commit_valid && r_pc_change[r_head];
  assign commit_rd     = commit_valid ? r_rd[r_head]              : '0;
  assign commit_dest   = commit_valid ? {1'b0, r_head} + TAGW'(1) : '0;
  assign commit_result = commit_valid ? r_result[r_head]          : '0;
  assign commit_pc     = commit_valid ? r_pc[r_head]              : '0;
  assign commit_npc    = commit_valid ? r_npc[r_head]             : '0;
  assign count         = r_count;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_lkp
      logic [TAGW-1:0] w_tag;
      logic [IDXW-1:0] w_idx;
      logic            w_rdy;
      logic [XLEN-1:0] w_data;

      assign w_tag = (g == 0) ? lkp_tag_a : lkp_tag_b;
      assign w_idx = IDXW'(w_tag - TAGW'(1));

      // Same-cycle writeback takes priority over the stored result.
      always_comb begin
        w_rdy  = 1'b0;
        w_data = '0;
        if (w_tag == '0) begin
          w_rdy = 1'b1;
        end else if ((w_tag <= c_full) && r_busy[w_idx]) begin
          if (w_wb_hit && (wb_dest == w_tag)) begin
            w_rdy  = 1'b1;
            w_data = wb_result;
          end else if (r_done[w_idx]) begin
            w_rdy  = 1'b1;
            w_data = r_result[w_idx];
          end
        end
      end
    end
  endgenerate

  assign lkp_ready_a = g_lkp[0].w_rdy;
  assign lkp_data_a  = g_lkp[0].w_data;
  assign lkp_ready_b = g_lkp[1].w_rdy;
  assign lkp_data_b  = g_lkp[1].w_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy      <= '0;
      r_done      <= '0;
      r_pc_change <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
        r_rd[i]     <= '0;
        r_pc[i]     <= '0;
        r_result[i] <= '0;
        r_npc[i]    <= '0;
      end
    end else if (flush) begin
      r_busy      <= '0;
      r_done      <= '0;
      r_pc_change <= '0;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
    end else begin
      if (w_wb_hit) begin
        r_done[w_wb_idx]      <= 1'b1;
        r_result[w_wb_idx]    <= wb_result;
        r_npc[w_wb_idx]       <= wb_npc;
        r_pc_change[w_wb_idx] <= wb_pc_change;
      end
      // Placed after writeback so a retiring entry's done bit is cleared.
      if (commit_valid) begin
        r_busy[r_head] <= 1'b0;
        r_done[r_head] <= 1'b0;
        r_head         <= r_head + IDXW'(1);
      end
      if (w_alloc_fire) begin
        r_busy[r_tail]      <= 1'b1;
        r_done[r_tail]      <= 1'b0;
        r_pc_change[r_tail] <= 1'b0;
        r_rd[r_tail]        <= alloc_rd;
        r_pc[r_tail]        <= alloc_pc;
        r_tail              <= r_tail + IDXW'(1);
      end
      r_count <= r_count + TAGW'(w_alloc_fire) - TAGW'(commit_valid);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_rob.sv
// ============================================================================
// Module   : tb_ysyx_rob
// Brief    : Directed self-checking bench for the ysyx_rob reorder buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ysyx_rob;

  localparam int ROB_SIZE = 4;
  localparam int XLEN     = 32;
  localparam int TAGW     = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            alloc_valid;
  logic [4:0]      alloc_rd;
  logic [XLEN-1:0] alloc_pc;
  logic            alloc_ready;
  logic [TAGW-1:0] alloc_dest;
  logic            wb_valid;
  logic [TAGW-1:0] wb_dest;
  logic [XLEN-1:0] wb_result;
  logic [XLEN-1:0] wb_npc;
  logic            wb_pc_change;
  logic [TAGW-1:0] lkp_tag_a;
  logic [TAGW-1:0] lkp_tag_b;
  logic            lkp_ready_a;
  logic            lkp_ready_b;
  logic [XLEN-1:0] lkp_data_a;
  logic [XLEN-1:0] lkp_data_b;
  logic            commit_valid;
  logic [4:0]      commit_rd;
  logic [TAGW-1:0] commit_dest;
  logic [XLEN-1:0] commit_result;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_npc;
  logic            flush;
  logic [TAGW-1:0] count;

  int n_checks = 0;
  int n_fail   = 0;

  ysyx_rob #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_pc(alloc_pc),
    .alloc_ready(alloc_ready), .alloc_dest(alloc_dest),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result),
    .wb_npc(wb_npc), .wb_pc_change(wb_pc_change),
    .lkp_tag_a(lkp_tag_a), .lkp_tag_b(lkp_tag_b),
    .lkp_ready_a(lkp_ready_a), .lkp_ready_b(lkp_ready_b),
    .lkp_data_a(lkp_data_a), .lkp_data_b(lkp_data_b),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_dest(commit_dest),
    .commit_result(commit_result), .commit_pc(commit_pc), .commit_npc(commit_npc),
    .flush(flush), .count(count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    alloc_valid  = 1'b0;
    alloc_rd     = '0;
    alloc_pc     = '0;
    wb_valid     = 1'b0;
    wb_dest      = '0;
    wb_result    = '0;
    wb_npc       = '0;
    wb_pc_change = 1'b0;
    lkp_tag_a    = '0;
    lkp_tag_b    = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [31:0] pc);
    alloc_valid = 1'b1;
    alloc_rd    = rd;
    alloc_pc    = pc;
    step();
    alloc_valid = 1'b0;
  endtask

  task automatic wb(input logic [TAGW-1:0] tag, input logic [31:0] res,
                    input logic [31:0] npc, input logic pcc);
    wb_valid     = 1'b1;
    wb_dest      = tag;
    wb_result    = res;
    wb_npc       = npc;
    wb_pc_change = pcc;
    step();
    wb_valid     = 1'b0;
    wb_pc_change = 1'b0;
  endtask

  initial begin
    int k;
    int n_alloc;
    int n_commit;

    // Reset state
    do_reset();
    lkp_tag_b = 3'd1;
    #1;
    check("rst_alloc_ready", alloc_ready, 1);
    check("rst_alloc_dest", alloc_dest, 1);
    check("rst_count", count, 0);
    check("rst_commit_valid", commit_valid, 0);
    check("rst_flush", flush, 0);
    check("rst_commit_pc", commit_pc, 0);
    check("rst_lkp0_ready", lkp_ready_a, 1);
    check("rst_lkp1_ready", lkp_ready_b, 0);

    // Fill beyond capacity: 5th request is dropped
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1'b1;
      alloc_rd    = 5'(i + 1);
      alloc_pc    = 32'h8000_0000 + 32'(4 * i);
      #1;
      check("fill_ready", alloc_ready, (i < 4) ? 1 : 0);
      if (i < 4) check("fill_dest", alloc_dest, i + 1);
      step();
    end
    idle();
    lkp_tag_a = 3'd4;
    #1;
    check("fill_count", count, 4);
    check("fill_ready_after", alloc_ready, 0);
    check("fill_lkp_pending", lkp_ready_a, 0);

    // Out-of-order writeback 3,1,2 retires in order 1,2,3
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 1), 32'h8000_0000 + 32'(4 * i));
    wb_valid = 1'b1; wb_dest = 3'd3; wb_result = 32'h33; wb_npc = 32'h8000_000c;
    #1;
    check("ooo_no_commit_a", commit_valid, 0);
    step();
    wb_dest = 3'd1; wb_result = 32'h11; wb_npc = 32'h8000_0004;
    #1;
    check("ooo_no_commit_b", commit_valid, 0);
    step();
    wb_dest = 3'd2; wb_result = 32'h22; wb_npc = 32'h8000_0008;
    #1;
    check("ooo_c1_valid", commit_valid, 1);
    check("ooo_c1_dest", commit_dest, 1);
    check("ooo_c1_rd", commit_rd, 1);
    check("ooo_c1_result", commit_result, 32'h11);
    step();
    wb_valid = 1'b0;
    #1;
    check("ooo_c2_valid", commit_valid, 1);
    check("ooo_c2_dest", commit_dest, 2);
    check("ooo_c2_rd", commit_rd, 2);
    check("ooo_c2_result", commit_result, 32'h22);
    step();
    #1;
    check("ooo_c3_valid", commit_valid, 1);
    check("ooo_c3_dest", commit_dest, 3);
    check("ooo_c3_pc", commit_pc, 32'h8000_0008);
    check("ooo_c3_result", commit_result, 32'h33);
    step();
    #1;
    check("ooo_count_end", count, 0);
    check("ooo_idle", commit_valid, 0);

    // Lookup bypass and last-write-wins
    do_reset();
    alloc(5'd1, 32'h8000_0000);
    alloc(5'd2, 32'h8000_0004);
    lkp_tag_a = 3'd2;
    #1;
    check("lkp_pending_ready", lkp_ready_a, 0);
    check("lkp_pending_data", lkp_data_a, 0);
    wb_valid = 1'b1; wb_dest = 3'd2; wb_result = 32'hDEAD_BEEF; wb_npc = 32'h8000_0008;
    lkp_tag_b = 3'd0;
    #1;
    check("lkp_bypass_ready", lkp_ready_a, 1);
    check("lkp_bypass_data", lkp_data_a, 32'hDEAD_BEEF);
    check("lkp_tag0_ready", lkp_ready_b, 1);
    check("lkp_tag0_data", lkp_data_b, 0);
    step();
    wb_valid = 1'b0;
    lkp_tag_b = 3'd1;
    #1;
    check("lkp_done_ready", lkp_ready_a, 1);
    check("lkp_done_data", lkp_data_a, 32'hDEAD_BEEF);
    check("lkp_notdone_ready", lkp_ready_b, 0);
    wb(3'd2, 32'h1234_5678, 32'h8000_0008, 1'b0);
    wb(3'd1, 32'hAA, 32'h8000_0004, 1'b0);
    #1;
    check("lww_c1_result", commit_result, 32'hAA);
    step();
    #1;
    check("lww_c2_result", commit_result, 32'h1234_5678);

    // Full with simultaneous commit: no same-cycle reuse
    do_reset();
    for (int i = 0; i < 4; i++) alloc(5'(i + 1), 32'h8000_0000 + 32'(4 * i));
    wb(3'd1, 32'h1, 32'h8000_0004, 1'b0);
    alloc_valid = 1'b1; alloc_rd = 5'd10; alloc_pc = 32'h9000_0000;
    #1;
    check("full_commit_valid", commit_valid, 1);
    check("full_alloc_ready", alloc_ready, 0);
    step();
    alloc_valid = 1'b0;
    #1;
    check("full_count_after", count, 3);
    check("full_ready_after", alloc_ready, 1);
    check("full_dest_wrap", alloc_dest, 1);
    check("full_head_pending", commit_valid, 0);

    // Flush on a retiring control-flow change
    do_reset();
    for (int i = 0; i < 3; i++) alloc(5'(i + 5), 32'h8000_0200 + 32'(4 * i));
    wb(3'd1, 32'h0, 32'h8000_0100, 1'b1);
    alloc_valid = 1'b1; alloc_rd = 5'd9; alloc_pc = 32'h8000_0300;
    #1;
    check("flush_commit_valid", commit_valid, 1);
    check("flush_flag", flush, 1);
    check("flush_npc", commit_npc, 32'h8000_0100);
    check("flush_rd", commit_rd, 5);
    check("flush_alloc_ready", alloc_ready, 1);
    step();
    alloc_valid = 1'b0;
    #1;
    check("flush_count", count, 0);
    check("flush_dest", alloc_dest, 1);
    check("flush_clear", flush, 0);
    wb(3'd2, 32'h55, 32'h8000_0208, 1'b0);
    lkp_tag_a = 3'd2;
    #1;
    check("flush_stale_wb_count", count, 0);
    check("flush_stale_wb_commit", commit_valid, 0);
    check("flush_stale_lkp", lkp_ready_a, 0);

    // Wrap-around stream: alloc instr c, write back instr c-1, commit instr c-2
    do_reset();
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c < 10) begin
        alloc_valid = 1'b1;
        alloc_rd    = 5'(c + 1);
        alloc_pc    = 32'h8000_1000 + 32'(4 * c);
      end
      if (c >= 1 && c <= 10) begin
        k = c - 1;
        wb_valid  = 1'b1;
        wb_dest   = TAGW'((k % 4) + 1);
        wb_result = 32'h1000 + 32'(k);
        wb_npc    = 32'h8000_1000 + 32'(4 * k + 4);
      end
      #1;
      if (c < 10) begin
        check("wrap_alloc_dest", alloc_dest, (c % 4) + 1);
        check("wrap_alloc_ready", alloc_ready, 1);
      end
      check("wrap_commit_valid", commit_valid, (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        k = c - 2;
        check("wrap_commit_dest", commit_dest, (k % 4) + 1);
        check("wrap_commit_pc", commit_pc, 32'h8000_1000 + 32'(4 * k));
        check("wrap_commit_rd", commit_rd, k + 1);
      end
      n_alloc  = (c < 10) ? c : 10;
      n_commit = (c >= 2) ? c - 2 : 0;
      check("wrap_count", count, n_alloc - n_commit);
      step();
    end
    idle();
    #1;
    check("wrap_count_end", count, 0);

    // Asynchronous reset with a commit pending
    alloc(5'd1, 32'h8000_2000);
    alloc(5'd2, 32'h8000_2004);
    wb(3'd3, 32'h77, 32'h8000_2004, 1'b1);
    #1;
    check("areset_pre_commit", commit_valid, 1);
    check("areset_pre_flush", flush, 1);
    reset = 1'b1;
    #1;
    check("areset_commit_valid", commit_valid, 0);
    check("areset_flush", flush, 0);
    check("areset_count", count, 0);
    check("areset_alloc_dest", alloc_dest, 1);
    check("areset_alloc_ready", alloc_ready, 1);
    step();
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
